seq_fsm_pattern2_gen: RTL

- Serial pattern generator: the transmit side of the "run of ones, then a zero" serial protocol.
- On each accepted request it drives a burst of N consecutive 1s on a one-bit serial line, then one terminating 0, then a programmable idle gap of 0s.
- Used as the stimulus source and loopback driver for the team's serial pattern detectors.
- A valid/ready request port feeds it; the serial output feeds any 1110-style detector.

---
 rtl/seq_pattern_pkg.sv | 27 ++
 rtl/seq_pattern_down_cnt.sv | 38 +++
 rtl/seq_fsm_pattern2_gen.sv | 91 +++++++++
 3 files changed

// File: rtl/seq_pattern_pkg.sv
// -----------------------------------------------------------------------------
// seq_pattern_pkg
// Shared definitions for the serial "run of ones, then a zero" pattern
// generator:
//   state_e          - generator FSM states (2-bit encoding)
//   MIN_ONES_DEFAULT - default minimum burst length
//   clamp_ones()     - raises a requested burst length to the minimum
// -----------------------------------------------------------------------------
package seq_pattern_pkg;

    // ST_ prefix keeps the state names clear of the GAP parameter in the top.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ONES = 2'd1,
        ST_TERM = 2'd2,
        ST_GAP  = 2'd3
    } state_e;

    localparam int unsigned MIN_ONES_DEFAULT = 3;

    // Burst length actually produced for a request.
    function automatic int unsigned clamp_ones(input int unsigned req,
                                               input int unsigned min_ones);
        return (req < min_ones) ? min_ones : req;
    endfunction

endpackage

// File: rtl/seq_pattern_down_cnt.sv
// -----------------------------------------------------------------------------
// seq_pattern_down_cnt
// Loadable down-counter that saturates at zero.
// Ports:
//   clk        - clock, rising edge
//   rst_n      - asynchronous active-low reset, clears the count
//   load_i     - load load_val_i this cycle (has priority over dec_i)
//   load_val_i - value to load
//   dec_i      - decrement by one when the count is non-zero
//   zero_o     - count is zero
// -----------------------------------------------------------------------------
module seq_pattern_down_cnt #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q;

    // NOTE: registers are written with <= so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/seq_fsm_pattern2_gen.sv
// -----------------------------------------------------------------------------
// seq_fsm_pattern2_gen
// Serial pattern generator: per accepted request, n ones, one terminating
// zero, then GAP idle zeros. n = max(req_ones, MIN_ONES).
// Ports:
//   clk      - clock, rising edge
//   reset    - asynchronous active-low reset
//   req_val  - request valid
//   req_rdy  - request ready (IDLE and out of reset)
//   req_ones - requested number of ones (CNT_W bits)
//   out      - serial pattern bit (1 only while in ONES)
//   busy     - generator is not IDLE
//   done     - one-cycle pulse with the terminating zero
// -----------------------------------------------------------------------------
module seq_fsm_pattern2_gen
    import seq_pattern_pkg::*;
#(
    parameter int unsigned CNT_W    = 4,
    parameter int unsigned MIN_ONES = MIN_ONES_DEFAULT,
    parameter int unsigned GAP      = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_val,
    output logic             req_rdy,
    input  logic [CNT_W-1:0] req_ones,
    output logic             out,
    output logic             busy,
    output logic             done
);

    // A zero-width counter is illegal, so GAP=0 still gets a (unused) 1-bit one.
    localparam int unsigned GAP_W = (GAP > 0) ? $clog2(GAP + 1) : 1;

    state_e             state_q;
    logic               xfer;
    logic [CNT_W-1:0]   ones_load_val;
    logic               ones_zero;
    logic               gap_load;
    logic [GAP_W-1:0]   gap_load_val;
    logic               gap_zero;

    assign xfer = req_val && req_rdy;

    // Counter holds "ones still to send after this one", hence n-1.
    assign ones_load_val = CNT_W'(clamp_ones(32'(req_ones), MIN_ONES) - 32'd1);

    seq_pattern_down_cnt #(.W(CNT_W)) u_ones_cnt (
        .clk        (clk),
        .rst_n      (reset),
        .load_i     (xfer),
        .load_val_i (ones_load_val),
        .dec_i      (state_q == ST_ONES),
        .zero_o     (ones_zero)
    );

    assign gap_load     = (state_q == ST_TERM) && (GAP != 0);
    assign gap_load_val = GAP_W'(GAP - 1);

    seq_pattern_down_cnt #(.W(GAP_W)) u_gap_cnt (
        .clk        (clk),
        .rst_n      (reset),
        .load_i     (gap_load),
        .load_val_i (gap_load_val),
        .dec_i      (state_q == ST_GAP),
        .zero_o     (gap_zero)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: if (xfer) state_q <= ST_ONES;
                ST_ONES: if (ones_zero) state_q <= ST_TERM;
                ST_TERM: state_q <= (GAP == 0) ? ST_IDLE : ST_GAP;
                ST_GAP:  if (gap_zero) state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Moore decode of the state register. State is already forced to IDLE
    // during reset; req_rdy additionally masks with reset so no transfer can
    // be offered while reset is held.
    assign out     = (state_q == ST_ONES);
    assign done    = (state_q == ST_TERM);
    assign busy    = (state_q != ST_IDLE);
    assign req_rdy = (state_q == ST_IDLE) && reset;

endmodule
